// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pll_lock_sequencer                                            |
// | Brief    : PLL reset sequencing, debounced lock, lock retry and dynamic  |
// |            phase-step control. Phase-step path: PLL_SEQ_PHASE_SHIFT_EN  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3,
  parameter int PS_PULSE     = 4,
  parameter int PS_GAP       = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       pll_extlock,
  output logic       pll_reset,
  input  logic       ps_req,
  input  logic       ps_dir,
  input  logic [2:0] ps_sel,
  output logic       ps_ack,
  output logic [2:0] pll_psclksel,
  output logic       pll_psstep,
  output logic       pll_psdown,
  output logic       locked,
  output logic       user_rst_n,
  output logic [3:0] retry_cnt,
  output logic       fault
);

  localparam int c_sw   = $clog2(LOCK_STABLE + 1);
  localparam int c_tw   = $clog2(LOCK_TIMEOUT + 1);
  localparam int c_pmax = (RST_CYCLES > PS_PULSE)
                        ? ((RST_CYCLES > PS_GAP) ? RST_CYCLES : PS_GAP)
                        : ((PS_PULSE > PS_GAP) ? PS_PULSE : PS_GAP);
  localparam int c_cw   = $clog2(c_pmax + 1);

  localparam logic [c_sw-1:0] c_stable_last  = c_sw'(LOCK_STABLE - 1);
  localparam logic [c_tw-1:0] c_timeout_last = c_tw'(LOCK_TIMEOUT - 1);
  localparam logic [c_cw-1:0] c_rst_last     = c_cw'(RST_CYCLES - 1);
  localparam logic [3:0]      c_max_retry    = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST      = 3'd0,
    S_WAIT     = 3'd1,
    S_LOCKED   = 3'd2,
    S_PS_SETUP = 3'd3,
    S_PS_STEP  = 3'd4,
    S_PS_GAP   = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sync;
  logic [c_sw-1:0] r_stable;
  logic [c_tw-1:0] r_timeout;
  logic [c_cw-1:0] r_cnt;
  logic            w_lock_s;

  assign w_lock_s = r_sync[1];

`ifdef PLL_SEQ_PHASE_SHIFT_EN
  localparam logic [c_cw-1:0] c_pulse_last = c_cw'(PS_PULSE - 1);
  localparam logic [c_cw-1:0] c_gap_last   = c_cw'(PS_GAP - 1);

  logic       r_ps_ack;
  logic       r_psstep;
  logic       r_psdown;
  logic [2:0] r_psclksel;

  assign ps_ack       = r_ps_ack;
  assign pll_psstep   = r_psstep;
  assign pll_psdown   = r_psdown;
  assign pll_psclksel = r_psclksel;
`else
  logic w_unused_ps;

  assign w_unused_ps  = ^{ps_req, ps_dir, ps_sel};
  assign ps_ack       = 1'b0;
  assign pll_psstep   = 1'b0;
  assign pll_psdown   = 1'b0;
  assign pll_psclksel = 3'd0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state    <= S_RST;
      r_sync     <= '0;
      r_stable   <= '0;
      r_timeout  <= '0;
      r_cnt      <= '0;
      pll_reset  <= 1'b1;
      locked     <= 1'b0;
      user_rst_n <= 1'b0;
      retry_cnt  <= 4'd0;
      fault      <= 1'b0;
`ifdef PLL_SEQ_PHASE_SHIFT_EN
      r_ps_ack   <= 1'b0;
      r_psstep   <= 1'b0;
      r_psdown   <= 1'b0;
      r_psclksel <= 3'd0;
`endif
    end else begin
      r_sync <= {r_sync[0], pll_extlock};
`ifdef PLL_SEQ_PHASE_SHIFT_EN
      r_ps_ack <= 1'b0;
`endif
      case (r_state)
        S_RST: begin
          if (r_cnt == c_rst_last) begin
            r_state   <= S_WAIT;
            pll_reset <= 1'b0;
            r_stable  <= '0;
            r_timeout <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Lock qualification wins over a timeout landing in the same cycle.
        S_WAIT: begin
          r_timeout <= r_timeout + 1'b1;
          r_stable  <= w_lock_s ? (r_stable + 1'b1) : '0;
          if (w_lock_s && (r_stable == c_stable_last)) begin
            r_state    <= S_LOCKED;
            locked     <= 1'b1;
            user_rst_n <= 1'b1;
          end else if (r_timeout == c_timeout_last) begin
            pll_reset <= 1'b1;
            if (retry_cnt < c_max_retry) begin
              retry_cnt <= retry_cnt + 1'b1;
              r_state   <= S_RST;
              r_cnt     <= '0;
            end else begin
              r_state <= S_FAULT;
              fault   <= 1'b1;
            end
          end
        end

        S_LOCKED, S_PS_SETUP, S_PS_STEP, S_PS_GAP: begin
          if (!w_lock_s) begin
            // Any in-flight step is abandoned silently; retry_cnt untouched.
            r_state    <= S_RST;
            r_cnt      <= '0;
            pll_reset  <= 1'b1;
            locked     <= 1'b0;
            user_rst_n <= 1'b0;
`ifdef PLL_SEQ_PHASE_SHIFT_EN
            r_psstep   <= 1'b0;
`endif
          end else begin
`ifdef PLL_SEQ_PHASE_SHIFT_EN
            case (r_state)
              S_LOCKED: begin
                if (ps_req && !r_ps_ack) begin
                  r_psclksel <= ps_sel;
                  r_psdown   <= ps_dir;
                  r_state    <= S_PS_SETUP;
                end
              end
              S_PS_SETUP: begin
                r_state  <= S_PS_STEP;
                r_psstep <= 1'b1;
                r_cnt    <= '0;
              end
              S_PS_STEP: begin
                if (r_cnt == c_pulse_last) begin
                  r_state  <= S_PS_GAP;
                  r_psstep <= 1'b0;
                  r_cnt    <= '0;
                end else begin
                  r_cnt <= r_cnt + 1'b1;
                end
              end
              S_PS_GAP: begin
                if (r_cnt == c_gap_last) begin
                  r_state  <= S_LOCKED;
                  r_ps_ack <= 1'b1;
                end else begin
                  r_cnt <= r_cnt + 1'b1;
                end
              end
              default: r_state <= S_LOCKED;
            endcase
`endif
          end
        end

        S_FAULT: begin
          pll_reset  <= 1'b1;
          fault      <= 1'b1;
          user_rst_n <= 1'b0;
        end

        default: begin
          r_state   <= S_RST;
          r_cnt     <= '0;
          pll_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pll_lock_sequencer                                         |
// | Brief    : Directed/randomized bench with a phase-level reference model  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 32;
  localparam int MAX_RETRY    = 2;
  localparam int PS_PULSE     = 2;
  localparam int PS_GAP       = 3;
`ifdef PLL_SEQ_PHASE_SHIFT_EN
  localparam bit PS_EN = 1'b1;
`else
  localparam bit PS_EN = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pll_extlock = 1'b0;
  logic       ps_req = 1'b0;
  logic       ps_dir = 1'b0;
  logic [2:0] ps_sel = 3'd0;
  logic       pll_reset, ps_ack, pll_psstep, pll_psdown, locked, user_rst_n, fault;
  logic [2:0] pll_psclksel;
  logic [3:0] retry_cnt;

  pll_lock_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .MAX_RETRY(MAX_RETRY), .PS_PULSE(PS_PULSE), .PS_GAP(PS_GAP)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pll_extlock(pll_extlock),
    .pll_reset(pll_reset), .ps_req(ps_req), .ps_dir(ps_dir), .ps_sel(ps_sel),
    .ps_ack(ps_ack), .pll_psclksel(pll_psclksel), .pll_psstep(pll_psstep),
    .pll_psdown(pll_psdown), .locked(locked), .user_rst_n(user_rst_n),
    .retry_cnt(retry_cnt), .fault(fault)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: which phase the controller is in and how long it has been there.
  typedef enum int {P_RST, P_WAIT, P_LOCKED, P_PS, P_FAULT} phase_e;
  phase_e     m_phase = P_RST;
  int         m_age = 0;
  int         m_run = 0;
  int         m_retry = 0;
  logic       m_s1 = 1'b0, m_s2 = 1'b0, m_ack = 1'b0, m_down = 1'b0;
  logic [2:0] m_sel = 3'd0;

  function automatic void enter(phase_e p);
    m_phase = p;
    m_age   = 0;
    m_run   = 0;
  endfunction

  task automatic model_step();
    logic ls, prev_ack;
    if (!sys_rst_n) begin
      enter(P_RST);
      m_s1 = 1'b0; m_s2 = 1'b0; m_retry = 0;
      m_sel = 3'd0; m_down = 1'b0; m_ack = 1'b0;
      return;
    end
    ls       = m_s2;
    m_s2     = m_s1;
    m_s1     = pll_extlock;
    prev_ack = m_ack;
    m_ack    = 1'b0;
    m_age++;
    case (m_phase)
      P_RST: if (m_age == RST_CYCLES) enter(P_WAIT);
      P_WAIT: begin
        m_run = ls ? m_run + 1 : 0;
        if (m_run == LOCK_STABLE) enter(P_LOCKED);
        else if (m_age == LOCK_TIMEOUT) begin
          if (m_retry < MAX_RETRY) begin
            m_retry++;
            enter(P_RST);
          end else begin
            enter(P_FAULT);
          end
        end
      end
      P_LOCKED: begin
        if (!ls) enter(P_RST);
        else if (PS_EN && ps_req && !prev_ack) begin
          m_sel  = ps_sel;
          m_down = ps_dir;
          enter(P_PS);
        end
      end
      P_PS: begin
        if (!ls) enter(P_RST);
        else if (m_age == 1 + PS_PULSE + PS_GAP) begin
          enter(P_LOCKED);
          m_ack = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic up;
    up = (m_phase == P_LOCKED) || (m_phase == P_PS);
    chk("pll_reset", pll_reset, (m_phase == P_RST) || (m_phase == P_FAULT));
    chk("locked", locked, up);
    chk("user_rst_n", user_rst_n, up);
    chk("fault", fault, m_phase == P_FAULT);
    chk("retry_cnt", retry_cnt, 4'(m_retry));
    chk("ps_ack", ps_ack, m_ack);
    chk("pll_psstep", pll_psstep, (m_phase == P_PS) && (m_age >= 1) && (m_age <= PS_PULSE));
    chk("pll_psdown", pll_psdown, m_down);
    chk("pll_psclksel", pll_psclksel, m_sel);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    cyc++;
    @(negedge sys_clk);
    check_outputs();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Requester: hold ps_req until ps_ack, optionally one cycle longer.
  task automatic do_step(logic [2:0] sel, logic dir, bit late);
    bit seen;
    int high;
    seen = 0;
    high = 0;
    ps_sel = sel;
    ps_dir = dir;
    ps_req = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (pll_psstep) high++;
      if (ps_ack) seen = 1;
    end
    chk("ps_ack_seen", 4'(seen), 4'(PS_EN));
    chk("psstep_width", 4'(high), PS_EN ? 4'(PS_PULSE) : 4'd0);
    if (late) tick();
    ps_req = 1'b0;
    tick();
  endtask

  initial begin
    bit seen;
    // Reset values, extlock already high
    pll_extlock = 1'b1;
    ticks(3);
    chk("reset_pll_reset", pll_reset, 4'd1);
    chk("reset_user_rst_n", user_rst_n, 4'd0);

    // Clean lock
    sys_rst_n = 1'b1;
    ticks(20);
    chk("clean_locked", locked, 4'd1);
    chk("clean_retry", retry_cnt, 4'd0);

    // Phase steps: fixed case plus randomized ones
    do_step(3'd3, 1'b1, 1'b1);
    chk("step_sel", pll_psclksel, PS_EN ? 4'd3 : 4'd0);
    chk("step_down", pll_psdown, PS_EN ? 4'd1 : 4'd0);
    chk("step_locked", locked, 4'd1);
    for (int k = 0; k < 5; k++) begin
      do_step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      ticks($urandom_range(0, 3));
    end

    // Glitchy lock: loss, then high/low/high during qualification
    pll_extlock = 1'b0; tick();
    pll_extlock = 1'b1; ticks(9);
    pll_extlock = 1'b0; tick();
    pll_extlock = 1'b1; ticks(20);
    chk("glitch_relocked", locked, 4'd1);

    // Lock loss mid-step
    ps_sel = 3'd1; ps_dir = 1'b0; ps_req = 1'b1;
    for (int i = 0; i < 10 && !pll_psstep; i++) tick();
    pll_extlock = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ps_ack) seen = 1;
    end
    ps_req = 1'b0;
    chk("loss_no_ack", 4'(seen), 4'd0);
    chk("loss_user_rst_n", user_rst_n, 4'd0);
    pll_extlock = 1'b1;
    ticks(20);
    chk("loss_relocked", locked, 4'd1);
    chk("loss_retry_same", retry_cnt, 4'd0);

    // Randomized extlock noise with a rule-abiding requester
    for (int i = 0; i < 200; i++) begin
      pll_extlock = ($urandom_range(0, 99) < 94);
      if (ps_req && ps_ack) ps_req = 1'b0;
      else if (!ps_req && ($urandom_range(0, 3) == 0)) begin
        ps_req = 1'b1;
        ps_sel = 3'($urandom_range(0, 7));
        ps_dir = 1'($urandom_range(0, 1));
      end
      tick();
    end
    ps_req = 1'b0;

    // Retry to fault
    pll_extlock = 1'b0;
    ticks(3 * (RST_CYCLES + LOCK_TIMEOUT) + 14);
    chk("fault_set", fault, 4'd1);
    chk("fault_retry", retry_cnt, 4'(MAX_RETRY));
    pll_extlock = 1'b1;
    ticks(30);
    chk("fault_held", fault, 4'd1);
    chk("fault_pll_reset", pll_reset, 4'd1);

    // Reset recovers; then reset mid-step
    sys_rst_n = 1'b0; ticks(2);
    sys_rst_n = 1'b1; ticks(16);
    chk("recover_locked", locked, 4'd1);
    chk("recover_retry", retry_cnt, 4'd0);
    ps_sel = 3'd6; ps_dir = 1'b1; ps_req = 1'b1;
    for (int i = 0; i < 10 && !pll_psstep; i++) tick();
    sys_rst_n = 1'b0; ps_req = 1'b0;
    tick();
    chk("rst_mid_psstep", pll_psstep, 4'd0);
    sys_rst_n = 1'b1;
    ticks(16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Controller for the on-chip PLL wrapper: sequences PLL reset, qualifies the asynchronous `extlock` into a debounced `locked`, retries failed lock attempts, and issues dynamic phase-shift steps on request. Sits between the PLL instance and the clocking/reset logic of the top level. Its `user_rst_n` is the reset that holds downstream logic until the PLL clocks are trustworthy.

## Interface

Parameters:

- `RST_CYCLES`, 16: width of the `pll_reset` pulse, in cycles.
- `LOCK_STABLE`, 1024: consecutive cycles synchronized lock must stay high.
- `LOCK_TIMEOUT`, 65536: maximum cycles spent waiting for lock per attempt.
- `MAX_RETRY`, 3: timeouts tolerated before fault; range 1..15.
- `PS_PULSE`, 4: cycles `pll_psstep` is held high.
- `PS_GAP`, 8: quiet cycles after a step before acknowledge.

Ports:

- `sys_clk` in 1: sole clock. It also drives the PLL `psclk` externally.
- `sys_rst_n` in 1: synchronous, active-low reset.
- `pll_extlock` in 1: PLL lock, asynchronous to `sys_clk`.
- `pll_reset` out 1: PLL reset, active-high.
- `ps_req` in 1: phase-step request, level.
- `ps_dir` in 1: 1 = step down (phase retard), 0 = step up.
- `ps_sel` in 3: output counter (`clkc` index 0..4) to shift.
- `ps_ack` out 1: one-cycle completion pulse.
- `pll_psclksel` out 3: to PLL.
- `pll_psstep` out 1: to PLL.
- `pll_psdown` out 1: to PLL.
- `locked` out 1: qualified lock.
- `user_rst_n` out 1: downstream reset, active-low.
- `retry_cnt` out 4: lock timeouts since `sys_rst_n`.
- `fault` out 1: retries exhausted.

## Operation

- `pll_extlock` passes through a 2-FF synchronizer, producing `lock_s`.
- All outputs are registered.
- Reset values: `pll_reset`=1, `locked`=0, `user_rst_n`=0, `ps_ack`=0, `pll_psstep`=0, `pll_psdown`=0, `pll_psclksel`=0, `retry_cnt`=0, `fault`=0. The state is RST.
- RST: `pll_reset`=1 for exactly `RST_CYCLES` cycles, then go to WAIT.
- WAIT: `pll_reset`=0.
  - A stable counter increments while `lock_s`=1 and clears when `lock_s`=0.
  - A timeout counter increments every cycle.
  - Stable count reaching `LOCK_STABLE` → LOCKED.
  - Otherwise, timeout reaching `LOCK_TIMEOUT` with `retry_cnt`<`MAX_RETRY` → `retry_cnt`++ and go to RST.
  - Timeout with `retry_cnt`=`MAX_RETRY` → FAULT.
  - If stability and timeout occur in the same cycle, lock wins.
  - Both counters clear on entry to WAIT.
- LOCKED: `locked`=1, `user_rst_n`=1.
  - `ps_req`=1 and `ps_ack`=0 → latch `ps_sel` into `pll_psclksel` and `ps_dir` into `pll_psdown`, then go to PS_SETUP.
- PS_SETUP: 1 cycle with sel/down stable and `pll_psstep`=0.
- PS_STEP: `pll_psstep`=1 for `PS_PULSE` cycles.
- PS_GAP: `pll_psstep`=0 for `PS_GAP` cycles. Then return to LOCKED with `ps_ack`=1 for one cycle.
- `ps_sel` values 5..7 are accepted and complete normally. The PLL ignores them; the block does no checking.
- Requester rule: hold `ps_req` until `ps_ack` is seen, then drop it. The ack cycle cannot accept a new request.
- Lock loss: `lock_s`=0 in LOCKED or any PS_* state → go to RST.
  - Next cycle: `locked`=0, `user_rst_n`=0, `pll_psstep`=0.
  - An in-flight request is abandoned with no `ps_ack`.
  - `retry_cnt` is unchanged.
  - Lock loss has priority over `ps_req`.
- FAULT: `pll_reset`=1, `fault`=1, `user_rst_n`=0. Exit only via `sys_rst_n`.
- `sys_rst_n`=0 in any state restores reset values on the next edge, including mid-step (`pll_psstep` drops).

## Timing

- `pll_extlock` rise to `lock_s`: 2 cycles.
- Earliest `locked` after `sys_rst_n` release: `RST_CYCLES` + 2 + `LOCK_STABLE` cycles, within ±1 cycle of entry registration.
- Request accept (LOCKED, `ps_req`=1) to `pll_psstep` rise: 2 cycles.
- Total accept-to-`ps_ack`: 1 + 1 + `PS_PULSE` + `PS_GAP` cycles.
- `pll_psclksel` and `pll_psdown` change only on accept. They are stable from 1 cycle before `pll_psstep` rise until the next accept.
- `lock_s` fall to `locked`/`user_rst_n` low: 1 cycle.

## Configuration

- `PLL_SEQ_PHASE_SHIFT_EN` defined: phase-shift path present as described above.
- Not defined:
  - PS_* states and request latching are omitted.
  - `ps_req`, `ps_dir` and `ps_sel` are ignored.
  - `ps_ack`, `pll_psstep`, `pll_psdown` and `pll_psclksel` are constant 0.
  - Lock sequencing is identical.

## Test plan

Bench parameters: `RST_CYCLES`=4, `LOCK_STABLE`=8, `LOCK_TIMEOUT`=32, `MAX_RETRY`=2, `PS_PULSE`=2, `PS_GAP`=3.

- Clean lock: `pll_extlock`=1 from cycle 0 → `pll_reset` high 4 cycles, then `locked` and `user_rst_n` rise about 10 cycles later. `retry_cnt`=0.
- Glitchy lock: `extlock` high 5 cycles, low 1, high steady → the stable count restarts and `locked` rises 8 cycles after the last rise plus 2 sync cycles.
- Retry to fault: `extlock`=0 permanently → 2 retries (`retry_cnt`=1, then 2), third timeout → `fault`=1 and `pll_reset`=1, held until `sys_rst_n` pulse.
- Phase step: while locked, `ps_req`=1, `ps_sel`=3, `ps_dir`=1 → `pll_psclksel`=3 and `pll_psdown`=1; `pll_psstep` high 2 cycles starting 2 cycles after accept; `ps_ack` pulses 7 cycles after accept; held `ps_req` is not re-accepted in the ack cycle.
- Lock loss mid-step: drop `extlock` during PS_STEP → `pll_psstep` low, `user_rst_n`=0, no `ps_ack`, RST re-entered, relock succeeds with `retry_cnt` unchanged.
- Macro off: repeat the phase-step scenario → `pll_psstep`, `ps_ack` and `pll_psclksel` stay 0 while `locked` stays 1.
